// File: rtl/data_sram_ctrl.sv
// Data-memory bus responder that turns core load/store requests into
// multi-cycle asynchronous SRAM reads and writes, stalling the pipeline
// until each access completes.
// Optional: define SRAM_FWD_BUF_EN to add a one-entry last-write buffer that
// serves read hits without an SRAM cycle.
module data_sram_ctrl #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_ce_i,
  input  logic              ram_we_i,
  input  logic [31:0]       ram_addr_i,
  input  logic [3:0]        ram_sel_i,
  input  logic [31:0]       ram_data_i,
  output logic [31:0]       ram_data_o,
  output logic              stallreq_o,
  output logic              bus_err_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_data_o,
  input  logic [31:0]       sram_data_i,
  output logic              sram_data_oe_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [31:0]         ram_data_d;
  logic                bus_err_d;
  logic [ADDR_W-1:0]   sram_addr_d;
  logic [31:0]         sram_data_d;
  logic                sram_data_oe_d;
  logic                sram_ce_n_d;
  logic                sram_oe_n_d;
  logic                sram_we_n_d;
  logic [3:0]          sram_be_n_d;
  logic                in_window;
  logic                fwd_hit;
  logic [31:0]         fwd_data;
  logic                unused_addr_lsb;

  assign in_window       = ram_addr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
  assign unused_addr_lsb = ^ram_addr_i[1:0];

  // Stall is forced low while reset is held, even though the FSM sits in idle.
  assign stallreq_o = rst & ram_ce_i & in_window & (state_q != StDone);

`ifdef SRAM_FWD_BUF_EN
  logic              buf_valid_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [31:0]       buf_data_q;

  assign fwd_hit  = buf_valid_q & ~ram_we_i & (buf_addr_q == ram_addr_i[ADDR_W+1:2]);
  assign fwd_data = buf_data_q;

  // Last-write buffer: full-word writes load it, partial writes to its word invalidate it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else if (state_q == StDone && we_q) begin
      if (sram_be_n_o == 4'h0) begin
        buf_valid_q <= 1'b1;
        buf_addr_q  <= sram_addr_o;
        buf_data_q  <= sram_data_o;
      end else if (buf_addr_q == sram_addr_o) begin
        buf_valid_q <= 1'b0;
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // Next-state and registered SRAM strobe/data values.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    we_d           = we_q;
    ram_data_d     = ram_data_o;
    bus_err_d      = 1'b0;
    sram_addr_d    = sram_addr_o;
    sram_data_d    = sram_data_o;
    sram_data_oe_d = sram_data_oe_o;
    sram_ce_n_d    = sram_ce_n_o;
    sram_oe_n_d    = sram_oe_n_o;
    sram_we_n_d    = sram_we_n_o;
    sram_be_n_d    = sram_be_n_o;
    unique case (state_q)
      StIdle: begin
        if (ram_ce_i) begin
          if (!in_window) begin
            ram_data_d = '0;
            bus_err_d  = 1'b1;
          end else if (fwd_hit) begin
            // Clear we so the done cycle does not touch the buffer.
            we_d       = 1'b0;
            ram_data_d = fwd_data;
            state_d    = StDone;
          end else begin
            // Address, byte enables and data settle one cycle before the strobes.
            we_d           = ram_we_i;
            sram_addr_d    = ram_addr_i[ADDR_W+1:2];
            sram_be_n_d    = ~ram_sel_i;
            sram_data_d    = ram_data_i;
            sram_ce_n_d    = 1'b0;
            sram_oe_n_d    = ram_we_i;
            sram_data_oe_d = ram_we_i;
            state_d        = StSetup;
          end
        end
      end
      StSetup: begin
        sram_we_n_d = ~we_q;
        cnt_d       = 4'(WAIT_CYCLES - 1);
        state_d     = StAccess;
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) ram_data_d = sram_data_i;
          sram_we_n_d = 1'b1;
          sram_oe_n_d = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        // Address and data stay put this cycle for hold time.
        sram_ce_n_d    = 1'b1;
        sram_data_oe_d = 1'b0;
        sram_be_n_d    = 4'hF;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      we_q           <= 1'b0;
      ram_data_o     <= '0;
      bus_err_o      <= 1'b0;
      sram_addr_o    <= '0;
      sram_data_o    <= '0;
      sram_data_oe_o <= 1'b0;
      sram_ce_n_o    <= 1'b1;
      sram_oe_n_o    <= 1'b1;
      sram_we_n_o    <= 1'b1;
      sram_be_n_o    <= 4'hF;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      we_q           <= we_d;
      ram_data_o     <= ram_data_d;
      bus_err_o      <= bus_err_d;
      sram_addr_o    <= sram_addr_d;
      sram_data_o    <= sram_data_d;
      sram_data_oe_o <= sram_data_oe_d;
      sram_ce_n_o    <= sram_ce_n_d;
      sram_oe_n_o    <= sram_oe_n_d;
      sram_we_n_o    <= sram_we_n_d;
      sram_be_n_o    <= sram_be_n_d;
    end
  end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Bench for data_sram_ctrl: two instances (WAIT_CYCLES 2 and 1) share the
// request fields, each with its own request-valid and SRAM model, and every
// access is checked against a word-level memory model.
module tb_data_sram_ctrl;

  localparam int unsigned AW = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    ce;
  logic          we;
  logic [31:0]   addr, wdata;
  logic [3:0]    sel;
  logic [31:0]   rdata  [2];
  logic          stall  [2];
  logic          berr   [2];
  logic [AW-1:0] saddr  [2];
  logic [31:0]   sdo    [2];
  logic [31:0]   sdi    [2];
  logic          soe    [2];
  logic          ce_n   [2];
  logic          oe_n   [2];
  logic          we_n   [2];
  logic [3:0]    be_n   [2];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] ref_mem [64];
  logic [31:0] last_rd = 32'h0;
  bit          bv = 1'b0;
  logic [19:0] ba = '0;
  logic [31:0] bd = '0;

  data_sram_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(2), .BASE_ADDR(32'h8000_0000)) dut0 (
    .clk(clk), .rst(rst), .ram_ce_i(ce[0]), .ram_we_i(we), .ram_addr_i(addr),
    .ram_sel_i(sel), .ram_data_i(wdata), .ram_data_o(rdata[0]), .stallreq_o(stall[0]),
    .bus_err_o(berr[0]), .sram_addr_o(saddr[0]), .sram_data_o(sdo[0]), .sram_data_i(sdi[0]),
    .sram_data_oe_o(soe[0]), .sram_ce_n_o(ce_n[0]), .sram_oe_n_o(oe_n[0]),
    .sram_we_n_o(we_n[0]), .sram_be_n_o(be_n[0])
  );

  data_sram_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(1), .BASE_ADDR(32'h8000_0000)) dut1 (
    .clk(clk), .rst(rst), .ram_ce_i(ce[1]), .ram_we_i(we), .ram_addr_i(addr),
    .ram_sel_i(sel), .ram_data_i(wdata), .ram_data_o(rdata[1]), .stallreq_o(stall[1]),
    .bus_err_o(berr[1]), .sram_addr_o(saddr[1]), .sram_data_o(sdo[1]), .sram_data_i(sdi[1]),
    .sram_data_oe_o(soe[1]), .sram_ce_n_o(ce_n[1]), .sram_oe_n_o(oe_n[1]),
    .sram_we_n_o(we_n[1]), .sram_be_n_o(be_n[1])
  );

  // Simple asynchronous SRAM per instance (low 1K words decoded).
  for (genvar g = 0; g < 2; g++) begin : g_sram
    logic [31:0] mem [1024];
    always @(posedge clk) begin
      if (!ce_n[g] && !we_n[g]) begin
        for (int b = 0; b < 4; b++) begin
          if (!be_n[g][b]) mem[saddr[g][9:0]][8*b +: 8] <= sdo[g][8*b +: 8];
        end
      end
    end
    assign sdi[g] = (!ce_n[g] && !oe_n[g]) ? mem[saddr[g][9:0]] : 32'h0;
  end

  function automatic int wc(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One core transaction on both instances; starts and ends just after a posedge.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d);
    int          stalls [2];
    int          wen    [2];
    int          oen    [2];
    bit          fin    [2];
    logic [31:0] rd     [2];
    int          guard;
    bit          inwin;
    bit          hit;
    logic [19:0] word;
    logic [3:0]  nbe;
    logic [31:0] exp_rd;
    inwin = (a[31:22] == 10'h200);
    word  = a[21:2];
    nbe   = ~s;
    hit   = 1'b0;
`ifdef SRAM_FWD_BUF_EN
    hit = inwin && !w && bv && (ba == word);
`endif
    for (int i = 0; i < 2; i++) begin
      stalls[i] = 0; wen[i] = 0; oen[i] = 0; fin[i] = 1'b0; rd[i] = '0;
    end
    we = w; addr = a; sel = s; wdata = d; ce = 2'b11;
    guard = 0;
    while (ce != 2'b00 && guard < 40) begin
      @(negedge clk);
      guard++;
      for (int i = 0; i < 2; i++) begin
        if (ce[i] && !fin[i]) begin
          if (guard == 1) chk("idle_ce_n", 32'(ce_n[i]), 32'd1);
          if (!we_n[i]) begin
            wen[i]++;
            chk("wr_addr", 32'(saddr[i]), 32'(word));
            chk("wr_be_n", 32'(be_n[i]), 32'(nbe));
            chk("wr_data", sdo[i], d);
            chk("wr_data_oe", 32'(soe[i]), 32'd1);
          end
          if (!oe_n[i]) begin
            oen[i]++;
            chk("rd_addr", 32'(saddr[i]), 32'(word));
            chk("rd_be_n", 32'(be_n[i]), 32'(nbe));
            chk("rd_data_oe", 32'(soe[i]), 32'd0);
          end
          if (stall[i]) stalls[i]++;
          else begin
            fin[i] = 1'b1;
            rd[i]  = rdata[i];
          end
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) if (fin[i]) ce[i] = 1'b0;
    end
    chk("timeout", 32'(ce), 32'd0);
    ce = 2'b00;

    exp_rd = ref_mem[word[5:0]];
    for (int i = 0; i < 2; i++) begin
      if (!inwin) begin
        chk("oow_stall", 32'(stalls[i]), 32'd0);
        chk("oow_we", 32'(wen[i]), 32'd0);
        chk("oow_oe", 32'(oen[i]), 32'd0);
      end else if (hit) begin
        chk("hit_stall", 32'(stalls[i]), 32'd1);
        chk("hit_oe", 32'(oen[i]), 32'd0);
        chk("hit_data", rd[i], exp_rd);
      end else begin
        chk("stall_cycles", 32'(stalls[i]), 32'(2 + wc(i)));
        chk("we_cycles", 32'(wen[i]), w ? 32'(wc(i)) : 32'd0);
        chk("oe_seen", 32'(oen[i] != 0), 32'(!w));
        chk(w ? "wr_hold_rdata" : "rd_data", rd[i], w ? last_rd : exp_rd);
      end
    end

    if (!inwin) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("bus_err_pulse", 32'(berr[i]), 32'd1);
        chk("oow_rdata", rdata[i], 32'd0);
        chk("oow_ce_n", 32'(ce_n[i]), 32'd1);
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk("bus_err_end", 32'(berr[i]), 32'd0);
      @(posedge clk);
      #1;
      last_rd = 32'h0;
    end else if (w) begin
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[word[5:0]][8*b +: 8] = d[8*b +: 8];
      if (s == 4'hF) begin
        bv = 1'b1; ba = word; bd = d;
      end else if (ba == word) begin
        bv = 1'b0;
      end
    end else begin
      last_rd = exp_rd;
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [3:0]  rs;
    for (int k = 0; k < 64; k++) ref_mem[k] = 32'h0;
    rst = 1'b0; ce = 2'b00; we = 1'b0; addr = '0; sel = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset values, with an in-window request presented during reset.
    ce = 2'b11; we = 1'b0; addr = 32'h8000_0010; sel = 4'hF;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_rdata", rdata[i], 32'h0);
      chk("rst_berr", 32'(berr[i]), 32'd0);
      chk("rst_addr", 32'(saddr[i]), 32'd0);
      chk("rst_sdo", sdo[i], 32'h0);
      chk("rst_soe", 32'(soe[i]), 32'd0);
      chk("rst_ce_n", 32'(ce_n[i]), 32'd1);
      chk("rst_oe_n", 32'(oe_n[i]), 32'd1);
      chk("rst_we_n", 32'(we_n[i]), 32'd1);
      chk("rst_be_n", 32'(be_n[i]), 32'hF);
      chk("rst_stall", 32'(stall[i]), 32'd0);
    end
    ce = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a write's access phase.
    we = 1'b1; addr = 32'h8000_0010; sel = 4'hF; wdata = 32'h5555_AAAA; ce = 2'b11;
    @(posedge clk);
    @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) chk("acc_we_n_low", 32'(we_n[i]), 32'd0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("midrst_we_n", 32'(we_n[i]), 32'd1);
      chk("midrst_ce_n", 32'(ce_n[i]), 32'd1);
      chk("midrst_soe", 32'(soe[i]), 32'd0);
      chk("midrst_stall", 32'(stall[i]), 32'd0);
    end
    ce = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill the model-visible words so later reads have known contents.
    for (int k = 0; k < 64; k++) access(1'b1, 32'h8000_0000 + 32'(4 * k), 4'hF, $urandom);

    // Full write then readback.
    access(1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF);
    access(1'b0, 32'h8000_0010, 4'hF, 32'h0);
    // Single-byte-lane merge.
    access(1'b1, 32'h8000_0020, 4'hF, 32'h1122_3344);
    access(1'b1, 32'h8000_0020, 4'b0010, 32'h0000_AA00);
    access(1'b0, 32'h8000_0020, 4'hF, 32'h0);
    // Write with no byte enables leaves the word alone.
    access(1'b1, 32'h8000_0020, 4'h0, 32'hFFFF_FFFF);
    access(1'b0, 32'h8000_0020, 4'hF, 32'h0);
    // Out-of-window read.
    access(1'b0, 32'h0000_0100, 4'hF, 32'h0);
    // Back-to-back reads.
    access(1'b0, 32'h8000_0000, 4'hF, 32'h0);
    access(1'b0, 32'h8000_0004, 4'hF, 32'h0);
    // Last-write buffer hit, then invalidation by a partial write.
    access(1'b1, 32'h8000_0040, 4'hF, 32'hCAFE_F00D);
    access(1'b0, 32'h8000_0040, 4'hF, 32'h0);
    access(1'b1, 32'h8000_0040, 4'b0001, 32'h0000_0077);
    access(1'b0, 32'h8000_0040, 4'hF, 32'h0);

    // Randomised traffic.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) ra = $urandom & 32'h3FFF_FFFC;
      else ra = 32'h8000_0000 + 32'(4 * $urandom_range(0, 63));
      rs = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      access(1'($urandom_range(0, 1)), ra, rs, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sram_ctrl.md
Name: data_sram_ctrl

Overview:
- Responder end of the core's data-memory bus: accepts ram_ce/ram_we/ram_addr/ram_sel/ram_data requests from the CPU MEM stage.
- Converts each request into a multi-cycle asynchronous-SRAM read or write.
- Holds the pipeline through a stall request until the access completes, then returns read data.
- Sits between the CPU top and the board's 32-bit external SRAM.

Parameters:
ADDR_W, 20, SRAM word-address width; window = 4*2^ADDR_W bytes
WAIT_CYCLES, 2, cycles SRAM strobes are held active (legal 1..15)
BASE_ADDR, 32'h8000_0000, byte base of the window; bits [ADDR_W+1:0] ignored

Ports:
clk  in  1  system clock (the one clock)
rst  in  1  reset, asynchronous, active-low
ram_ce_i  in  1  request valid from core
ram_we_i  in  1  1=write, 0=read
ram_addr_i  in  32  byte address
ram_sel_i  in  4  byte enables, bit0 = bits[7:0]
ram_data_i  in  32  write data
ram_data_o  out  32  read data to core
stallreq_o  out  1  pipeline stall request to ctrl
bus_err_o  out  1  one-cycle pulse: out-of-window request
sram_addr_o  out  ADDR_W  SRAM word address
sram_data_o  out  32  SRAM write data
sram_data_i  in  32  SRAM read data
sram_data_oe_o  out  1  1 = drive SRAM data pins
sram_ce_n_o  out  1  chip enable, active-low
sram_oe_n_o  out  1  output enable, active-low
sram_we_n_o  out  1  write enable, active-low
sram_be_n_o  out  4  byte enables, active-low

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (any time, including mid-access):
  - FSM to IDLE.
  - ram_data_o=0, bus_err_o=0, sram_addr_o=0, sram_data_o=0, sram_data_oe_o=0.
  - sram_ce_n_o=1, sram_oe_n_o=1, sram_we_n_o=1, sram_be_n_o=4'hF.
  - stallreq_o=0 while reset is asserted.
- In-window: ram_addr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2].
- Core contract: request fields stay stable while stallreq_o=1. The core advances on the first edge where stallreq_o=0.
- stallreq_o (combinational): ram_ce_i & in_window & (state != DONE).
- FSM states:
  - IDLE:
    - If ram_ce_i and in-window, go to SETUP.
    - If ram_ce_i and out-of-window, stay in IDLE, pulse bus_err_o next cycle, ram_data_o <= 0, no SRAM activity, no stall.
  - SETUP (1 cycle):
    - Latch sram_addr_o <= ram_addr_i[ADDR_W+1:2].
    - Latch sram_be_n_o <= ~ram_sel_i; sram_data_o <= ram_data_i.
    - sram_ce_n_o <= 0.
    - Read: sram_oe_n_o <= 0. Write: sram_data_oe_o <= 1.
    - Load wait counter with WAIT_CYCLES-1. Go to ACCESS.
  - ACCESS:
    - Write: sram_we_n_o=0.
    - Counter decrements each cycle. At 0:
      - Read: capture ram_data_o <= sram_data_i.
      - Either: sram_we_n_o <= 1, sram_oe_n_o <= 1.
      - Go to DONE.
  - DONE (1 cycle, stall released):
    - sram_ce_n_o <= 1, sram_data_oe_o <= 0, sram_be_n_o <= 4'hF.
    - Address and data are held through this cycle (hold time).
    - Unconditionally return to IDLE. The next request is accepted from IDLE.
- Latency per in-window access: 2+WAIT_CYCLES stalled cycles, then 1 DONE cycle. Default = 4 stalled + 1.
- ram_sel_i=0 on a write: the SRAM cycle still runs with all byte enables high, so no bytes change.
- ram_data_o holds its value until the next completed read or out-of-window request.
- ram_ce_i dropping mid-access (contract violation): the access completes, and stallreq_o follows the equation.

Optional Feature:
- Macro: SRAM_FWD_BUF_EN.
- Defined:
  - One-entry last-write buffer (word address + data + valid). It is loaded at a write's DONE only when ram_sel_i=4'hF. Any partial write to the same word clears valid.
  - An in-window read hitting a valid entry completes with no SRAM cycle: FSM IDLE->DONE directly, ram_data_o <= buffer data, 1 stalled cycle.
  - Reset clears valid.
- Undefined: no buffer; every read takes the full SRAM cycle.

Test Plan:
1. Reset mid-ACCESS of a write to 0x8000_0010 -> sram_we_n_o/ce_n_o immediately 1, sram_data_oe_o=0, stallreq_o=0; after reset release the FSM is in IDLE.
2. Write 0x8000_0010, sel=4'hF, data 0xDEADBEEF; then read the same address -> sram_addr_o=0x00004, be_n=4'h0, we_n low for exactly 2 cycles, stallreq_o high 4 cycles per access, read returns 0xDEADBEEF.
3. Write sel=4'b0010, data 0x0000AA00 to 0x8000_0020 (prior content 0x11223344) -> be_n=4'b1101; readback = 0x1122AA44.
4. Read 0x0000_0100 (out-of-window) -> no stall, no SRAM strobes, bus_err_o pulses 1 cycle, ram_data_o=0.
5. Back-to-back reads 0x8000_0000 then 0x8000_0004 with WAIT_CYCLES=1 -> each takes 3 stalled cycles + DONE; sram_ce_n_o returns high for at least 1 cycle between them.
6. With SRAM_FWD_BUF_EN: full write 0x8000_0040=0xCAFEF00D, then read -> 1 stall cycle, no sram_oe_n_o assertion, data 0xCAFEF00D; after a partial write to the same word, a read takes the full SRAM cycle.
